// File: rtl/vive_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vive_pkg
// Description : Shared constants and types for the triad readout arbiter.
//               Holds the triad data width, the default requester count, the
//               arbiter state encoding and a small index-wrapping helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vive_pkg;

  // Width of one triad_manager sample word.
  localparam int TRIAD_DATA_W       = 68;

  // Default number of triad_manager requesters sharing the transmitter.
  localparam int NUM_TRIADS_DEFAULT = 4;

  // Arbiter state encoding.
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_LATCH   = 3'd1;
  localparam logic [STATE_W-1:0] ST_SEND    = 3'd2;
  localparam logic [STATE_W-1:0] ST_RELEASE = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAP     = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = ST_IDLE,
    S_LATCH   = ST_LATCH,
    S_SEND    = ST_SEND,
    S_RELEASE = ST_RELEASE,
    S_GAP     = ST_GAP
  } arb_state_t;

  // Wrap an index into the range 0..n-1 (used for the round-robin search).
  function automatic int wrap_index(input int idx, input int n);
    return idx % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/round_robin_picker.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_picker
// Description : Combinational round-robin selector. Searches req starting at
//               last_grant+1 and wrapping modulo NUM_TRIADS; returns the first
//               set index and a valid flag.
// Ports       : req        - synchronised request vector
//               last_grant - index granted most recently
//               grant      - selected index (meaningful when valid=1)
//               valid      - at least one request is pending
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_picker
  import vive_pkg::*;
#(
  parameter int NUM_TRIADS = NUM_TRIADS_DEFAULT,
  parameter int IDX_W      = $clog2(NUM_TRIADS)
) (
  input  logic [NUM_TRIADS-1:0] req,
  input  logic [IDX_W-1:0]      last_grant,
  output logic [IDX_W-1:0]      grant,
  output logic                  valid
);

  logic [IDX_W-1:0] idx;

  // The search visits last_grant+1 first and last_grant itself last, so the
  // most recently served requester has the lowest priority.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int off = 1; off <= NUM_TRIADS; off++) begin
      idx = IDX_W'(wrap_index(int'(last_grant) + off, NUM_TRIADS));
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/triad_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : triad_arbiter
// Description : Shares one serial_transmitter between NUM_TRIADS
//               triad_manager instances. Requests are synchronised into the
//               clk_12MHz domain, granted round-robin, the granted sample is
//               latched toward the UART, and the triad is released with a
//               reset_parser pulse once the transmitter acknowledges (or a
//               timeout forces the release).
// Ports       : clk_12MHz          - sole clock
//               rst_n              - asynchronous active-low reset
//               triad_data_avl     - per-triad request level (asynchronous)
//               triad_data         - concatenated triad samples
//               triad_reset_parser - one-hot release pulse to granted triad
//               tx_data_avl        - data-valid level to the transmitter
//               tx_data            - latched sample of the granted triad
//               tx_triad_id        - index of the granted triad
//               tx_reset_parser    - transmitter frame-complete pulse
//               busy               - arbiter not in IDLE
//               timeout_count      - saturating count of forced releases
// Revision    : 1.0 - initial release
// ============================================================================
module triad_arbiter
  import vive_pkg::*;
#(
  parameter int NUM_TRIADS     = NUM_TRIADS_DEFAULT,
  parameter int DATA_W         = TRIAD_DATA_W,
  parameter int ID_W           = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RELEASE_CYCLES = 1
) (
  input  logic                         clk_12MHz,
  input  logic                         rst_n,
  input  logic [NUM_TRIADS-1:0]        triad_data_avl,
  input  logic [NUM_TRIADS*DATA_W-1:0] triad_data,
  output logic [NUM_TRIADS-1:0]        triad_reset_parser,
  output logic                         tx_data_avl,
  output logic [DATA_W-1:0]            tx_data,
  output logic [ID_W-1:0]              tx_triad_id,
  input  logic                         tx_reset_parser,
  output logic                         busy,
  output logic [7:0]                   timeout_count
);

  localparam int IDX_W   = $clog2(NUM_TRIADS);
  // One counter serves SEND, RELEASE and GAP, so it is sized for the longer
  // of the two limits.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > RELEASE_CYCLES) ? TIMEOUT_CYCLES
                                                             : RELEASE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

  arb_state_t             state;
  arb_state_t             state_nx;
  logic [NUM_TRIADS-1:0]  req_meta;
  logic [NUM_TRIADS-1:0]  req_s;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       pick;
  logic                   pick_valid;
  logic [CNT_W-1:0]       cnt;
  logic                   timeout_hit;
  logic                   release_active;
  logic [DATA_W-1:0]      slice [NUM_TRIADS];

  // --------------------------------------------------------------------------
  // Data slices and one-hot release decode
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_TRIADS; i++) begin : g_slice
    assign slice[i]              = triad_data[i*DATA_W +: DATA_W];
    assign triad_reset_parser[i] = release_active && (grant == IDX_W'(i));
  end

  // --------------------------------------------------------------------------
  // Round-robin selection over the synchronised requests
  // --------------------------------------------------------------------------
  round_robin_picker #(
    .NUM_TRIADS (NUM_TRIADS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req        (req_s),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_valid)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx       = state;
    timeout_hit    = 1'b0;
    tx_data_avl    = 1'b0;
    release_active = 1'b0;
    busy           = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (pick_valid) begin
          state_nx = S_LATCH;
        end
      end
      S_LATCH: begin
        state_nx = S_SEND;
      end
      S_SEND: begin
        tx_data_avl = 1'b1;
        // An acknowledge wins over a simultaneous timeout.
        if (tx_reset_parser) begin
          state_nx = S_RELEASE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nx    = S_RELEASE;
          timeout_hit = 1'b1;
        end
      end
      S_RELEASE: begin
        release_active = 1'b1;
        if (cnt == RELEASE_LAST) begin
          state_nx = S_GAP;
        end
      end
      S_GAP: begin
        // Hold off until the released triad has visibly dropped its request,
        // otherwise its stale level would be granted a second time.
        if (!req_s[grant]) begin
          state_nx = S_IDLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nx    = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Synchroniser, counters, grant bookkeeping and transmit latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      req_meta      <= '0;
      req_s         <= '0;
      grant         <= '0;
      last_grant    <= IDX_W'(NUM_TRIADS - 1);
      cnt           <= '0;
      tx_data       <= '0;
      tx_triad_id   <= '0;
      timeout_count <= '0;
    end else begin
      req_meta <= triad_data_avl;
      req_s    <= req_meta;

      // The counter restarts on every state change and only advances in the
      // states that measure a duration.
      if (state_nx != state) begin
        cnt <= '0;
      end else if (state inside {S_SEND, S_RELEASE, S_GAP}) begin
        cnt <= cnt + 1'b1;
      end

      if (state == S_IDLE && pick_valid) begin
        grant      <= pick;
        last_grant <= pick;
      end

      // tx_data/tx_triad_id persist across release until the next grant.
      if (state == S_LATCH) begin
        tx_data     <= slice[grant];
        tx_triad_id <= ID_W'(grant);
      end

      if (timeout_hit && (timeout_count != 8'hFF)) begin
        timeout_count <= timeout_count + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_triad_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_triad_arbiter
// Description : Self-checking bench for triad_arbiter. A stimulus process
//               models the triads and the transmitter; a reference model
//               computes the expected grant order, frame lengths and timeout
//               counts into a scoreboard queue; a monitor pops and compares on
//               every tx_data_avl frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_triad_arbiter;

  localparam int N  = 4;
  localparam int DW = 68;
  localparam int IW = 3;
  localparam int T  = 64;
  localparam int R  = 1;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            len;   // expected high cycles of tx_data_avl, -1 = aborted
    int            to;    // expected timeout_count after the release
  } exp_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    avl   = '0;
  logic [DW-1:0]   tdata [N];
  logic [N*DW-1:0] data_bus;
  logic [N-1:0]    rel;
  logic            tx_avl;
  logic [DW-1:0]   tx_data;
  logic [IW-1:0]   tx_id;
  logic            ack   = 1'b0;
  logic            busy;
  logic [7:0]      to_cnt;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   model_last = N - 1;
  int   model_to = 0;
  int   plan  [N];
  int   stale [N];
  int   hold  [N];
  int   send_cnt = 0;

  for (genvar g = 0; g < N; g++) begin : g_bus
    assign data_bus[g*DW +: DW] = tdata[g];
  end

  triad_arbiter #(
    .NUM_TRIADS     (N),
    .DATA_W         (DW),
    .ID_W           (IW),
    .TIMEOUT_CYCLES (T),
    .RELEASE_CYCLES (R)
  ) dut (
    .clk_12MHz          (clk),
    .rst_n              (rst_n),
    .triad_data_avl     (avl),
    .triad_data         (data_bus),
    .triad_reset_parser (rel),
    .tx_data_avl        (tx_avl),
    .tx_data            (tx_data),
    .tx_triad_id        (tx_id),
    .tx_reset_parser    (ack),
    .busy               (busy),
    .timeout_count      (to_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending requesters are served in cyclic order starting after the last
  // served index; a frame lasts until the planned ack (1..T) or T cycles.
  task automatic push_exp(input logic [N-1:0] mask);
    int last_pick;
    last_pick = model_last;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (model_last + k) % N;
      if (mask[idx]) begin
        exp_t e;
        e.id   = idx;
        e.data = tdata[idx];
        e.len  = (plan[idx] == 0) ? T : plan[idx];
        if (plan[idx] == 0 && model_to < 255) model_to++;
        e.to   = model_to;
        exp_q.push_back(e);
        last_pick = idx;
      end
    end
    model_last = last_pick;
  endtask

  task automatic rand_data(input int i);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    tdata[i] = r[DW-1:0];
  endtask

  task automatic issue(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) if (mask[i]) rand_data(i);
    avl = avl | mask;
    push_exp(mask);
  endtask

  // ---------------- triad + transmitter behaviour, one cycle ----------------
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (rel[i]) begin
        if (stale[i] == 0) avl[i] = 1'b0;
        else begin
          hold[i]  = stale[i];
          stale[i] = 0;
        end
      end else if (hold[i] > 0) begin
        chk("stale_busy", busy, 1);
        chk("stale_no_frame", tx_avl, 0);
        hold[i]--;
        if (hold[i] == 0) avl[i] = 1'b0;
      end
    end
    if (tx_avl) begin
      send_cnt++;
      ack = 1'b0;
      if (int'(tx_id) < N) begin
        if (plan[int'(tx_id)] != 0 && send_cnt == plan[int'(tx_id)]) ack = 1'b1;
      end
    end else begin
      send_cnt = 0;
      ack      = 1'b0;
    end
  endtask

  task automatic run_idle(input int budget, input bit check_lat);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    do begin
      step();
      n++;
      if (!seen && tx_avl) begin
        seen = 1'b1;
        if (check_lat) chk("latency", n, 4);
      end
    end while ((avl != 0 || busy) && n < budget);
    chk("batch_done", (avl != 0 || busy), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit       prev;
    bit       have;
    int       len;
    exp_t     e;
    logic [N-1:0] exp_rel;
    prev = 1'b0;
    have = 1'b0;
    len  = 0;
    forever begin
      @(negedge clk);
      exp_rel = '0;
      if (tx_avl && !prev) begin
        len = 0;
        if (exp_q.size() == 0) begin
          have = 1'b0;
          chk("frame_unexpected", 1, 0);
        end else begin
          e    = exp_q.pop_front();
          have = 1'b1;
          chk("frame_id", tx_id, e.id);
          chk("frame_data", tx_data, e.data);
        end
      end
      if (tx_avl) len++;
      if (!tx_avl && prev && have) begin
        if (e.len >= 0) begin
          chk("frame_len", len, e.len);
          chk("timeout_count", to_cnt, e.to);
          chk("data_hold", tx_data, e.data);
          exp_rel = N'(1) << e.id;
        end
      end
      if (rel != '0 || exp_rel != '0) chk("release_pulse", rel, exp_rel);
      prev = tx_avl;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] mask;
    int           first;
    for (int i = 0; i < N; i++) begin
      tdata[i] = '0;
      plan[i]  = 1;
      stale[i] = 0;
      hold[i]  = 0;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_release", rel, 0);
    chk("rst_tx_avl", tx_avl, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_id", tx_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeouts", to_cnt, 0);
    rst_n = 1'b1;

    // single request with fixed data
    tdata[2] = 68'h0_DEAD_BEEF_0000_0001;
    plan[2]  = 3;
    avl[2]   = 1'b1;
    push_exp(4'b0100);
    run_idle(1000, 1'b1);

    // fairness: three holders, ack after 10 cycles, two rounds
    plan[0] = 10; plan[1] = 10; plan[3] = 10;
    issue(4'b1011);
    run_idle(1000, 1'b1);
    issue(4'b1011);
    run_idle(1000, 1'b1);

    // randomized batches
    repeat (25) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        plan[i]  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, T));
        stale[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
        if (!mask[i]) stale[i] = 0;
      end
      issue(mask);
      run_idle(N * (T + 40) + 100, 1'b1);
    end

    // ack on the same cycle the timeout would fire
    plan[1] = T;
    issue(4'b0010);
    run_idle(1000, 1'b1);
    chk("coincide_no_timeout", to_cnt, model_to);

    // stale level held 20 cycles after release
    plan[0]  = 5;
    stale[0] = 20;
    issue(4'b0001);
    run_idle(1000, 1'b1);

    // reset in the middle of SEND
    plan[1] = 0; plan[3] = 0;
    rand_data(1);
    rand_data(3);
    avl = avl | 4'b1010;
    first = ((model_last + 1) % N == 1 || (model_last + 1) % N == 2) ? 1 : 3;
    begin
      exp_t e;
      e.id   = first;
      e.data = tdata[first];
      e.len  = -1;
      e.to   = model_to;
      exp_q.push_back(e);
    end
    for (int n = 0; n < 20 && !tx_avl; n++) step();
    chk("send_before_reset", tx_avl, 1);
    repeat (5) step();
    rst_n = 1'b0;
    ack   = 1'b0;
    #1;
    chk("mid_rst_tx_avl", tx_avl, 0);
    chk("mid_rst_release", rel, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_tx_id", tx_id, 0);
    chk("mid_rst_timeouts", to_cnt, 0);
    model_last = N - 1;
    model_to   = 0;
    plan[1] = 7; plan[3] = 9;
    repeat (2) step();
    rst_n = 1'b1;
    push_exp(4'b1010);
    run_idle(1000, 1'b0);

    // repeated timeouts until the counter saturates
    plan[1] = 0;
    repeat (300) begin
      issue(4'b0010);
      run_idle(T + 60, 1'b1);
    end
    chk("timeout_saturated", to_cnt, 255);

    repeat (5) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
